tx_resp_sched: RTL
==================

Name: tx_resp_sched

Overview:
Response scheduler between the system controller's result sources and the UART transmitter. Buffers one pending response each from the register-file read path (8-bit) and the ALU (16-bit). Round-robin arbitrates between them, serialises the ALU result into two bytes, and drives the UART TX valid/busy handshake with a watchdog.

Parameters:
DATA_WIDTH, 8, UART byte width; the ALU result is 2*DATA_WIDTH.
ALU_HI_FIRST, 0, 0 = ALU low byte sent first, 1 = high byte first.
TIMEOUT, 255, cycles TX_D_VLD may wait for busy to rise before the byte is aborted; must be at least 1.

Ports:
Clk  in  1  system clock.
Rst  in  1  asynchronous active-low reset.
RdData  in  DATA_WIDTH  register-file read data.
RdData_valid  in  1  one-cycle strobe qualifying RdData.
ALU_OUT  in  2*DATA_WIDTH  ALU result.
OUT_valid  in  1  one-cycle strobe qualifying ALU_OUT.
busy  in  1  UART TX busy (high while a frame is shifting).
TX_P_DATA  out  DATA_WIDTH  byte to UART TX.
TX_D_VLD  out  1  byte valid to UART TX.
sched_busy  out  1  high when any slot is pending or a transfer is in progress.
overrun  out  1  one-cycle pulse: a strobe arrived for an occupied slot; the new data is dropped.
tx_timeout  out  1  one-cycle pulse: watchdog expired and the byte was aborted.

Behaviour:
- All outputs are registered. Reset values:
  - TX_P_DATA = 0; TX_D_VLD, sched_busy, overrun, tx_timeout = 0.
  - Both slots empty; round-robin pointer = RF; state = IDLE.
- Slot capture, per source:
  - A strobe with the slot empty loads the data and sets the pending flag on the next edge.
  - A strobe with the slot pending and not granted in that cycle is dropped, and overrun pulses on the next cycle.
  - A strobe in the same cycle the slot is granted loads the new data; no overrun.
  - Both strobes in the same cycle are both captured.
- Arbitration happens only in IDLE.
  - One slot pending: grant it.
  - Both pending: grant the source indicated by the pointer, then toggle the pointer to the other source.
  - The pointer does not change on an uncontested grant.
- The grant copies the slot into a 16-bit shift register, sets the byte count (RF = 1, ALU = 2) and clears the pending flag.
- FSM states: IDLE, SEND, WAIT_DONE.
  - IDLE -> SEND on grant. On that edge, TX_P_DATA is loaded with the first byte and TX_D_VLD is set to 1.
    - RF: RdData.
    - ALU: low byte, or high byte if ALU_HI_FIRST = 1.
    - Latency: strobe at cycle N -> pending at N+1 -> TX_D_VLD=1 at N+2 when idle and uncontested.
  - SEND: TX_D_VLD and TX_P_DATA are held stable. The watchdog counts cycles in SEND.
    - busy=1 sampled: clear TX_D_VLD, go to WAIT_DONE.
    - Watchdog reaches TIMEOUT with busy=0: clear TX_D_VLD, pulse tx_timeout, discard the remaining bytes of the response, go to IDLE.
  - WAIT_DONE: wait for busy=0.
    - Then, if bytes remain: load the next byte, set TX_D_VLD=1, go to SEND with the watchdog cleared.
    - Otherwise go to IDLE.
    - There is no watchdog in WAIT_DONE.
- busy already high on entry to SEND counts as acceptance; the next cycle is WAIT_DONE.
- sched_busy = (state != IDLE) | rf_pending | alu_pending, registered.
- Reset asserted mid-transfer clears everything immediately (asynchronous). A partially sent ALU response is lost; no recovery frame is sent.
- The watchdog counter is sized clog2(TIMEOUT+1) bits and saturates; it never wraps.

Test Plan:
1. RdData=0x5A with a strobe at cycle 10, busy responding 2 cycles after TX_D_VLD -> TX_D_VLD=1 at cycle 12 with TX_P_DATA=0x5A, then one byte only; IDLE after busy falls.
2. ALU_OUT=0xBEEF strobe with ALU_HI_FIRST=0 -> bytes 0xEF then 0xBE; TX_D_VLD is low between them until busy falls. Rerun with ALU_HI_FIRST=1 -> 0xBE then 0xEF.
3. RF 0x11 and ALU 0x2233 strobed in the same cycle, pointer=RF -> sequence 0x11, 0x33, 0x22. Repeat both strobes -> ALU first: 0x33, 0x22, 0x11.
4. Second RdData=0x77 strobe while the RF slot holds 0x66 during an ALU transfer -> overrun pulses one cycle; only 0x66 is transmitted.
5. TIMEOUT=4 with busy held at 0 on an ALU response -> TX_D_VLD drops, tx_timeout pulses once, the high byte is never sent, and the next pending RF byte is sent.
6. Rst low while in WAIT_DONE of ALU byte 1 -> TX_D_VLD=0, sched_busy=0 immediately. After release, no byte is sent until a new strobe.

Source files
------------

// File: rtl/tx_resp_sched.sv
// One-deep RF/ALU response slots, round-robin arbitrated and serialised to UART TX; strobe to TX_D_VLD takes 2 cycles.
// Backpressure: UART busy handshake with a SEND watchdog; a strobe into an occupied slot is dropped and flagged.
module tx_resp_sched #(
  parameter int DATA_WIDTH   = 8,
  parameter bit ALU_HI_FIRST = 1'b0,
  parameter int TIMEOUT      = 255
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_valid,
  input  logic                    busy,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    sched_busy,
  output logic                    overrun,
  output logic                    tx_timeout
);

  localparam int DW   = DATA_WIDTH;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t          state, state_nxt;
  logic            rf_pending, rf_pending_nxt;
  logic [DW-1:0]   rf_data, rf_data_nxt;
  logic            alu_pending, alu_pending_nxt;
  logic [2*DW-1:0] alu_data, alu_data_nxt;
  logic            rr_alu, rr_alu_nxt;
  logic [2*DW-1:0] shift_reg, shift_nxt;
  logic [1:0]      bytes_left, bytes_left_nxt;
  logic [WD_W-1:0] wdog, wdog_nxt;
  logic            tx_vld_nxt, overrun_nxt, timeout_nxt, sched_busy_nxt;
  logic            grant_rf, grant_alu;

  assign grant_rf  = (state == IDLE) && rf_pending  && (!alu_pending || !rr_alu);
  assign grant_alu = (state == IDLE) && alu_pending && (!rf_pending  ||  rr_alu);

  // The byte on the wire is always the low byte of the shift register.
  assign TX_P_DATA = shift_reg[DW-1:0];

  always_comb begin
    state_nxt       = state;
    rf_pending_nxt  = rf_pending;
    rf_data_nxt     = rf_data;
    alu_pending_nxt = alu_pending;
    alu_data_nxt    = alu_data;
    rr_alu_nxt      = rr_alu;
    shift_nxt       = shift_reg;
    bytes_left_nxt  = bytes_left;
    wdog_nxt        = wdog;
    tx_vld_nxt      = TX_D_VLD;
    overrun_nxt     = 1'b0;
    timeout_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (grant_rf) begin
          shift_nxt      = {{DW{1'b0}}, rf_data};
          bytes_left_nxt = 2'd1;
          rf_pending_nxt = 1'b0;
          if (alu_pending) rr_alu_nxt = 1'b1;
          tx_vld_nxt     = 1'b1;
          wdog_nxt       = '0;
          state_nxt      = SEND;
        end else if (grant_alu) begin
          // Arrange so the first byte sits low and the second shifts down later.
          shift_nxt       = ALU_HI_FIRST ? {alu_data[DW-1:0], alu_data[2*DW-1:DW]} : alu_data;
          bytes_left_nxt  = 2'd2;
          alu_pending_nxt = 1'b0;
          if (rf_pending) rr_alu_nxt = 1'b0;
          tx_vld_nxt      = 1'b1;
          wdog_nxt        = '0;
          state_nxt       = SEND;
        end
      end
      SEND: begin
        if (busy) begin
          tx_vld_nxt = 1'b0;
          state_nxt  = WAIT_DONE;
        end else if (wdog >= WD_LAST) begin
          tx_vld_nxt     = 1'b0;
          timeout_nxt    = 1'b1;
          bytes_left_nxt = 2'd0;
          state_nxt      = IDLE;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          if (bytes_left > 2'd1) begin
            shift_nxt      = {{DW{1'b0}}, shift_reg[2*DW-1:DW]};
            bytes_left_nxt = bytes_left - 2'd1;
            tx_vld_nxt     = 1'b1;
            wdog_nxt       = '0;
            state_nxt      = SEND;
          end else begin
            bytes_left_nxt = 2'd0;
            state_nxt      = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A slot being granted this cycle is free to take a new strobe.
    if (RdData_valid) begin
      if (!rf_pending || grant_rf) begin
        rf_data_nxt    = RdData;
        rf_pending_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end
    if (OUT_valid) begin
      if (!alu_pending || grant_alu) begin
        alu_data_nxt    = ALU_OUT;
        alu_pending_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end

    sched_busy_nxt = (state_nxt != IDLE) | rf_pending_nxt | alu_pending_nxt;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      rf_pending  <= 1'b0;
      rf_data     <= '0;
      alu_pending <= 1'b0;
      alu_data    <= '0;
      rr_alu      <= 1'b0;
      shift_reg   <= '0;
      bytes_left  <= 2'd0;
      wdog        <= '0;
      TX_D_VLD    <= 1'b0;
      sched_busy  <= 1'b0;
      overrun     <= 1'b0;
      tx_timeout  <= 1'b0;
    end else begin
      state       <= state_nxt;
      rf_pending  <= rf_pending_nxt;
      rf_data     <= rf_data_nxt;
      alu_pending <= alu_pending_nxt;
      alu_data    <= alu_data_nxt;
      rr_alu      <= rr_alu_nxt;
      shift_reg   <= shift_nxt;
      bytes_left  <= bytes_left_nxt;
      wdog        <= wdog_nxt;
      TX_D_VLD    <= tx_vld_nxt;
      sched_busy  <= sched_busy_nxt;
      overrun     <= overrun_nxt;
      tx_timeout  <= timeout_nxt;
    end
  end

endmodule
